// File: rtl/mem_resp_pkg.sv
// Purpose : shared types and constants for the memory responder slice.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: FSM state enum, ADDR_W/DEPTH defaults, fault-condition constants.
package mem_resp_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DEPTH_DEF  = 2048;

    // Any set bit of vaddr under this mask means the word access is misaligned.
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam logic [1:0] ALIGN_OK   = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FAULT,
        RESP
    } state_t;

    // A request faults when the decoder flagged it unmapped or it is not word aligned.
    function automatic logic isFault(input logic invalid, input logic [31:0] vaddr);
        return invalid || ((vaddr[1:0] & ALIGN_MASK) != ALIGN_OK);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Purpose : request/response/exception bundle between a requester (master) and mem_responder (slave).
// Latency : n/a (wires only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes; exc_clear is a one-cycle pulse.
interface mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_vaddr;
    logic [ADDR_W-1:0] req_paddr;
    logic              req_invalid;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic [31:0]       bad_vaddr;
    logic              exc_pending;
    logic              exc_clear;

    modport master (
        output req_valid, req_write, req_vaddr, req_paddr, req_invalid, req_wdata, req_be,
        output rsp_ready, exc_clear,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, bad_vaddr, exc_pending
    );

    modport slave (
        input  req_valid, req_write, req_vaddr, req_paddr, req_invalid, req_wdata, req_be,
        input  rsp_ready, exc_clear,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, bad_vaddr, exc_pending
    );

endinterface

// File: rtl/mem_resp_ram.sv
// Purpose : single-port DEPTH x 32 RAM with per-byte write enables; contents are never reset.
// Latency : read data registered, valid the cycle after en=1/we=0; writes land on the same edge.
// Backpressure: none; rdata holds its last read value while en is low or a write is in progress.
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Purpose : one-outstanding memory responder with fault detection and a sticky exception capture.
// Latency : request accepted in cycle T, response valid from cycle T+2 (one READ/WRITE/FAULT cycle between).
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready. Ports: clk, rst, bus (slave).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mem_responder_if.slave bus
);

    state_t            state;
    state_t            nextState;

    logic              capWrite;
    logic              capFault;
    logic [ADDR_W-1:0] capPaddr;
    logic [31:0]       capWdata;
    logic [3:0]        capBe;

    logic              excPending;
    logic [31:0]       badVaddr;

    logic              accept;
    logic              reqFault;
    logic              ramEn;
    logic              ramWe;
    logic [31:0]       ramRdata;

    assign accept   = bus.req_valid && (state == IDLE);
    assign reqFault = isFault(bus.req_invalid, bus.req_vaddr);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (reqFault)          nextState = FAULT;
                    else if (bus.req_write) nextState = WRITE;
                    else                    nextState = READ;
                end
            end
            READ, WRITE, FAULT: nextState = RESP;
            RESP: begin
                if (bus.rsp_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_error = 1'b0;
        bus.rsp_rdata = '0;
        ramEn         = 1'b0;
        ramWe         = 1'b0;
        case (state)
            IDLE:  bus.req_ready = 1'b1;
            READ:  ramEn = 1'b1;
            WRITE: begin
                ramEn = 1'b1;
                ramWe = 1'b1;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_error = capFault;
                // The RAM read register is untouched while in RESP, so this is stable.
                if (!capFault && !capWrite) bus.rsp_rdata = ramRdata;
            end
            default: ;
        endcase
    end

    // All request fields are sampled on the accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capWrite <= 1'b0;
            capFault <= 1'b0;
            capPaddr <= '0;
            capWdata <= '0;
            capBe    <= '0;
        end else if (accept) begin
            capWrite <= bus.req_write;
            capFault <= reqFault;
            capPaddr <= bus.req_paddr;
            capWdata <= bus.req_wdata;
            capBe    <= bus.req_be;
        end
    end

    // Exception capture is evaluated on the accept cycle of a faulting request.
    // A fault together with exc_clear counts as a fresh first fault (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excPending <= 1'b0;
            badVaddr   <= '0;
        end else if (accept && reqFault) begin
            if (!excPending || bus.exc_clear) badVaddr <= bus.req_vaddr;
            excPending <= 1'b1;
        end else if (bus.exc_clear) begin
            excPending <= 1'b0;
        end
    end

    assign bus.exc_pending = excPending;
    assign bus.bad_vaddr   = badVaddr;

    mem_resp_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) uRam (
        .clk   (clk),
        .en    (ramEn),
        .we    (ramWe),
        .be    (capBe),
        .addr  (capPaddr),
        .wdata (capWdata),
        .rdata (ramRdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : directed self-checking bench for mem_responder.
// Latency : checks the T+2 response timing on every transaction.
// Backpressure: exercises a stalled response and the no-overlap accept rule.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_responder_if #(.ADDR_W(11)) bus();

    mem_responder #(.ADDR_W(11), .DEPTH(2048)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drives one request at a falling edge, then waits (bounded) for rsp_valid.
    task automatic issue(input logic wr, input logic [31:0] va, input logic [10:0] pa,
                         input logic inv, input logic [31:0] wd, input logic [3:0] be,
                         input logic clr, output logic [31:0] rd, output logic er,
                         output int lat, output logic rdyAtReq);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_vaddr   = va;
        bus.req_paddr   = pa;
        bus.req_invalid = inv;
        bus.req_wdata   = wd;
        bus.req_be      = be;
        bus.exc_clear   = clr;
        rdyAtReq        = bus.req_ready;
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.exc_clear   = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_error;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_vaddr = 0; bus.req_paddr = 0;
        bus.req_invalid = 0; bus.req_wdata = 0; bus.req_be = 0;
        bus.rsp_ready = 1'b1; bus.exc_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got %b exp 0", bus.rsp_error); end
        checks++; if (bus.bad_vaddr !== 32'h0) begin errors++; $display("FAIL reset_bad_vaddr got %h exp 0", bus.bad_vaddr); end
        checks++; if (bus.exc_pending !== 1'b0) begin errors++; $display("FAIL reset_exc_pending got %b exp 0", bus.exc_pending); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1, 32'h10010014, 11'h005, 0, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", rdy); end
        checks++; if (lat != 2) begin errors++; $display("FAIL store_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_rsp got %h/%b exp 00000000/0", rd, er); end
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (lat != 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_rsp got %h/%b exp deadbeef/0", rd, er); end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1, 32'h10010014, 11'h005, 0, 32'h0000AB00, 4'b0010, 0, rd, er, lat, rdy);
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hDEADABEF) begin errors++; $display("FAIL partial_store got %h exp deadabef", rd); end
        // Store with no enabled lanes completes but leaves memory alone.
        issue(1, 32'h10010014, 11'h005, 0, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, rdy);
        checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL be0_rsp got lat %0d err %b exp 2/0", lat, er); end
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hDEADABEF) begin errors++; $display("FAIL be0_nochange got %h exp deadabef", rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(0, 32'h00400000, 11'h005, 1, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (lat != 2) begin errors++; $display("FAIL fault_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL fault_rsp got %h/%b exp 00000000/1", rd, er); end
        checks++; if (bus.bad_vaddr !== 32'h00400000) begin errors++; $display("FAIL fault_bad_vaddr got %h exp 00400000", bus.bad_vaddr); end
        checks++; if (bus.exc_pending !== 1'b1) begin errors++; $display("FAIL fault_pending got %b exp 1", bus.exc_pending); end
        // Faulting store must not write; second fault must not replace the address.
        issue(1, 32'h10010014, 11'h005, 1, 32'h12345678, 4'hF, 0, rd, er, lat, rdy);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL fault_store_err got %b exp 1", er); end
        checks++; if (bus.bad_vaddr !== 32'h00400000) begin errors++; $display("FAIL fault_hold got %h exp 00400000", bus.bad_vaddr); end
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hDEADABEF || er !== 1'b0) begin errors++; $display("FAIL fault_mem_intact got %h/%b exp deadabef/0", rd, er); end
        @(negedge clk);
        bus.exc_clear = 1'b1;
        @(negedge clk);
        bus.exc_clear = 1'b0;
        checks++; if (bus.exc_pending !== 1'b0) begin errors++; $display("FAIL clear_pending got %b exp 0", bus.exc_pending); end
        checks++; if (bus.bad_vaddr !== 32'h00400000) begin errors++; $display("FAIL clear_keeps_vaddr got %h exp 00400000", bus.bad_vaddr); end
    endtask

    task automatic test_sticky();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1, 32'h10010002, 11'h005, 0, 32'h00000000, 4'hF, 0, rd, er, lat, rdy);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", er); end
        checks++; if (bus.bad_vaddr !== 32'h10010002) begin errors++; $display("FAIL sticky_first got %h exp 10010002", bus.bad_vaddr); end
        issue(0, 32'h7FFFFFFF, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (bus.bad_vaddr !== 32'h10010002) begin errors++; $display("FAIL sticky_hold got %h exp 10010002", bus.bad_vaddr); end
        issue(0, 32'h7FFFEFFE, 11'h005, 0, 32'h0, 4'h0, 1, rd, er, lat, rdy);
        checks++; if (bus.exc_pending !== 1'b1) begin errors++; $display("FAIL set_wins_pending got %b exp 1", bus.exc_pending); end
        checks++; if (bus.bad_vaddr !== 32'h7FFFEFFE) begin errors++; $display("FAIL set_wins_vaddr got %h exp 7fffeffe", bus.bad_vaddr); end
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hDEADABEF) begin errors++; $display("FAIL misalign_no_write got %h exp deadabef", rd); end
    endtask

    task automatic test_boundary_addr();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1, 32'h10011FFC, 11'h7FF, 0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, rdy);
        issue(0, 32'h10011FFC, 11'h7FF, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL top_word got %h exp cafef00d", rd); end
        issue(1, 32'h10011FFC, 11'h7FF, 0, 32'h11223344, 4'b1001, 0, rd, er, lat, rdy);
        issue(0, 32'h10011FFC, 11'h7FF, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'h11FEF044) begin errors++; $display("FAIL top_word_be9 got %h exp 11fef044", rd); end
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hDEADABEF) begin errors++; $display("FAIL word5_isolated got %h exp deadabef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er, rdy; int lat;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (lat != 2 || rd !== 32'hDEADABEF) begin errors++; $display("FAIL bp_first got lat %0d %h exp 2 deadabef", lat, rd); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADABEF || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d got v%b %h r%b exp v1 deadabef r0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
        end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_pre_hs got v%b r%b exp v1 r0", bus.rsp_valid, bus.req_ready); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs got r%b v%b exp r1 v0", bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_reset_during_read();
        logic [31:0] rd; logic er, rdy; int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_vaddr = 32'h10010014;
        bus.req_paddr = 11'h005; bus.req_invalid = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_abort_valid got %b exp 0", bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.exc_pending !== 1'b0 || bus.bad_vaddr !== 32'h0) begin errors++; $display("FAIL rst_exc got %b %h exp 0 00000000", bus.exc_pending, bus.bad_vaddr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_idle got r%b v%b exp r1 v0", bus.req_ready, bus.rsp_valid); end
        issue(0, 32'h10010014, 11'h005, 0, 32'h0, 4'h0, 0, rd, er, lat, rdy);
        checks++; if (lat != 2 || rd !== 32'hDEADABEF || er !== 1'b0) begin errors++; $display("FAIL rst_mem_kept got lat %0d %h/%b exp 2 deadabef/0", lat, rd, er); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_fault();
        test_sticky();
        test_boundary_addr();
        test_backpressure();
        test_reset_during_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
